// File: rtl/falafel_mem_bridge_pkg.sv
// Shared types for the falafel memory bridge: request opcodes and bridge FSM states.
package falafel_pkg;
  localparam int FALAFEL_DATA_W = 64;

  typedef enum logic [1:0] {MEM_RD, MEM_WR, MEM_SWAP} mem_op_e;
  typedef enum logic [1:0] {BR_IDLE, BR_ISSUE, BR_RDATA} bridge_state_e;

  // A CAS flag without the write flag is treated as a plain read.
  function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
    if (!is_write) return MEM_RD;
    return is_cas ? MEM_SWAP : MEM_WR;
  endfunction
endpackage

// File: rtl/falafel_mem_bridge_if.sv
// Request/response handshake bundle between the allocator memory port and the bridge.
interface falafel_mem_bridge_if
  import falafel_pkg::*;
#(
  parameter int DATA_W = FALAFEL_DATA_W
);
  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic              mem_req_is_cas_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;

  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i, mem_req_addr_i,
           mem_req_data_i, mem_rsp_rdy_i,
    input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );

  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i, mem_req_addr_i,
           mem_req_data_i, mem_rsp_rdy_i,
    output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );
endinterface

// File: rtl/falafel_rsp_fifo.sv
// Small synchronous response FIFO; simultaneous push and pop leave the count unchanged.
module falafel_rsp_fifo #(
  parameter  int DATA_W    = 64,
  parameter  int RSP_DEPTH = 2,
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1),
  localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CNT_W'(RSP_DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data_i;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/falafel_mem_bridge.sv
// Serialises read/write/exchange requests onto a 1-cycle-latency single-port SRAM,
// one request in flight, with responses queued in a small FIFO.
module falafel_mem_bridge
  import falafel_pkg::*;
#(
  parameter  int DATA_W    = FALAFEL_DATA_W,
  parameter  int MEM_DEPTH = 1024,
  parameter  int RSP_DEPTH = 2,
  localparam int AW        = $clog2(MEM_DEPTH),
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1),
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  falafel_mem_bridge_if.slave  bus,
  output logic                 sram_en_o,
  output logic                 sram_we_o,
  output logic [AW-1:0]        sram_addr_o,
  output logic [DATA_W-1:0]    sram_wdata_o,
  input  logic [DATA_W-1:0]    sram_rdata_i,
  output logic                 err_o
);
  bridge_state_e     r_state, w_nxt;
  mem_op_e           r_op;
  logic [AW-1:0]     r_idx;
  logic              r_bad;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  logic [DATA_W-1:0] w_idx;
  logic              w_bad, w_rdy, w_accept;
  logic              w_en, w_we, w_push, w_set_err;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_wdata, w_push_data;
  logic              w_full, w_empty;
  logic [CNT_W-1:0]  w_count;

  // Range check uses the full address so high bits cannot alias into the SRAM.
  assign w_idx    = bus.mem_req_addr_i >> OFF_W;
  assign w_bad    = (|bus.mem_req_addr_i[OFF_W-1:0]) | (w_idx >= DATA_W'(MEM_DEPTH));
  assign w_rdy    = ~rst_i & (r_state == BR_IDLE) & (w_count < CNT_W'(RSP_DEPTH));
  assign w_accept = bus.mem_req_val_i & w_rdy;

  assign bus.mem_req_rdy_o = w_rdy;
  assign bus.mem_rsp_val_o = ~w_empty;
  assign sram_en_o    = w_en;
  assign sram_we_o    = w_we;
  assign sram_addr_o  = w_addr;
  assign sram_wdata_o = w_wdata;
  assign err_o        = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= BR_IDLE;
      r_op    <= MEM_RD;
      r_idx   <= '0;
      r_bad   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_op   <= decode_op(bus.mem_req_is_write_i, bus.mem_req_is_cas_i);
        r_idx  <= w_idx[AW-1:0];
        r_bad  <= w_bad;
        r_data <= bus.mem_req_data_i;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_push      = 1'b0;
    w_push_data = '0;
    w_set_err   = 1'b0;
    case (r_state)
      BR_IDLE: if (w_accept) w_nxt = BR_ISSUE;
      BR_ISSUE: begin
        if (r_bad) begin
          w_push      = 1'b1;
          w_push_data = '1;
          w_set_err   = 1'b1;
          w_nxt       = BR_IDLE;
        end else if (r_op == MEM_WR) begin
          w_en        = 1'b1;
          w_we        = 1'b1;
          w_addr      = r_idx;
          w_wdata     = r_data;
          w_push      = 1'b1;
          w_push_data = r_data;
          w_nxt       = BR_IDLE;
        end else begin
          w_en   = 1'b1;
          w_addr = r_idx;
          w_nxt  = BR_RDATA;
        end
      end
      BR_RDATA: begin
        // Old word goes back to the requester; SWAP overwrites it in the same cycle.
        w_push      = 1'b1;
        w_push_data = sram_rdata_i;
        w_nxt       = BR_IDLE;
        if (r_op == MEM_SWAP) begin
          w_en    = 1'b1;
          w_we    = 1'b1;
          w_addr  = r_idx;
          w_wdata = r_data;
        end
      end
      default: w_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) assert (!w_full || bus.mem_rsp_rdy_i);
  end

  falafel_rsp_fifo #(.DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (bus.mem_rsp_rdy_i),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count),
    .data_o      (bus.mem_rsp_data_o)
  );
endmodule

// File: tb/tb_falafel_mem_bridge.sv
// Directed bench for falafel_mem_bridge with a behavioural 1-cycle SRAM.
module tb_falafel_mem_bridge;
  localparam int DW = 64;
  localparam int MD = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  falafel_mem_bridge_if #(.DATA_W(DW)) bus();
  logic          sram_en, sram_we, err;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [DW-1:0] sram [MD];

  falafel_mem_bridge #(.DATA_W(DW), .MEM_DEPTH(MD), .RSP_DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .err_o        (err)
  );

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram[sram_addr] <= sram_wdata;
      else         sram_rdata      <= sram[sram_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Returns at the falling edge inside the ISSUE cycle (N+1).
  task automatic send(input logic w, input logic c, input logic [DW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    bus.mem_req_val_i = 1'b1; bus.mem_req_is_write_i = w; bus.mem_req_is_cas_i = c;
    bus.mem_req_addr_i = a; bus.mem_req_data_i = d;
    while (!bus.mem_req_rdy_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL send_timeout: rdy=0 want 1"); end
    @(negedge clk);
    bus.mem_req_val_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus.mem_rsp_val_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL rsp_timeout: val=0 want 1"); end
  endtask

  task automatic pop();
    bus.mem_rsp_rdy_i = 1'b1;
    @(negedge clk);
    bus.mem_rsp_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.mem_req_rdy_o !== 1'b0) begin miscompares++; $display("FAIL rst_rdy: got %b want 0", bus.mem_req_rdy_o); end
    vectors++; if (bus.mem_rsp_val_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_val: got %b want 0", bus.mem_rsp_val_o); end
    vectors++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin miscompares++; $display("FAIL rst_sram: en=%b we=%b want 0 0", sram_en, sram_we); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.mem_req_rdy_o !== 1'b1) begin miscompares++; $display("FAIL rel_rdy: got %b want 1", bus.mem_req_rdy_o); end
  endtask

  task automatic test_wr_rd();
    send(1'b1, 1'b0, 64'h40, 64'hDEAD);
    vectors++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'd8 || sram_wdata !== 64'hDEAD) begin
      miscompares++; $display("FAIL wr_issue: en=%b we=%b addr=%0d wdata=%h want 1 1 8 dead", sram_en, sram_we, sram_addr, sram_wdata); end
    vectors++; if (bus.mem_rsp_val_o !== 1'b0) begin miscompares++; $display("FAIL wr_n1_val: got %b want 0", bus.mem_rsp_val_o); end
    @(negedge clk);
    vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'hDEAD) begin
      miscompares++; $display("FAIL wr_n2_rsp: val=%b data=%h want 1 dead", bus.mem_rsp_val_o, bus.mem_rsp_data_o); end
    pop();
    send(1'b0, 1'b0, 64'h40, 64'h0);
    vectors++; if (sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 10'd8) begin
      miscompares++; $display("FAIL rd_issue: en=%b we=%b addr=%0d want 1 0 8", sram_en, sram_we, sram_addr); end
    @(negedge clk);
    vectors++; if (bus.mem_rsp_val_o !== 1'b0) begin miscompares++; $display("FAIL rd_n2_val: got %b want 0", bus.mem_rsp_val_o); end
    @(negedge clk);
    vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'hDEAD) begin
      miscompares++; $display("FAIL rd_n3_rsp: val=%b data=%h want 1 dead", bus.mem_rsp_val_o, bus.mem_rsp_data_o); end
    pop();
  endtask

  task automatic test_swap();
    send(1'b1, 1'b0, 64'h80, 64'h3);
    wait_rsp(); pop();
    send(1'b1, 1'b1, 64'h80, 64'h5);
    vectors++; if (sram_en !== 1'b1 || sram_we !== 1'b0) begin miscompares++; $display("FAIL swap_issue: en=%b we=%b want 1 0", sram_en, sram_we); end
    @(negedge clk);
    vectors++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'd16 || sram_wdata !== 64'h5) begin
      miscompares++; $display("FAIL swap_rdata: en=%b we=%b addr=%0d wdata=%h want 1 1 16 5", sram_en, sram_we, sram_addr, sram_wdata); end
    @(negedge clk);
    vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'h3) begin
      miscompares++; $display("FAIL swap_rsp: val=%b data=%h want 1 3", bus.mem_rsp_val_o, bus.mem_rsp_data_o); end
    pop();
    // CAS without write must behave as a read and leave memory alone
    send(1'b0, 1'b1, 64'h80, 64'h77);
    wait_rsp();
    vectors++; if (bus.mem_rsp_data_o !== 64'h5) begin miscompares++; $display("FAIL cas_as_rd: got %h want 5", bus.mem_rsp_data_o); end
    pop();
    send(1'b0, 1'b0, 64'h80, 64'h0);
    wait_rsp();
    vectors++; if (bus.mem_rsp_data_o !== 64'h5) begin miscompares++; $display("FAIL swap_readback: got %h want 5", bus.mem_rsp_data_o); end
    pop();
  endtask

  task automatic test_full();
    send(1'b1, 1'b0, 64'h100, 64'h11);
    send(1'b1, 1'b0, 64'h108, 64'h22);
    @(negedge clk);
    @(negedge clk);
    bus.mem_req_val_i = 1'b1; bus.mem_req_is_write_i = 1'b1; bus.mem_req_is_cas_i = 1'b0;
    bus.mem_req_addr_i = 64'h110; bus.mem_req_data_i = 64'h33;
    vectors++; if (bus.mem_req_rdy_o !== 1'b0) begin miscompares++; $display("FAIL full_rdy: got %b want 0", bus.mem_req_rdy_o); end
    repeat (2) @(negedge clk);
    vectors++; if (bus.mem_req_rdy_o !== 1'b0) begin miscompares++; $display("FAIL full_rdy_hold: got %b want 0", bus.mem_req_rdy_o); end
    vectors++; if (bus.mem_rsp_data_o !== 64'h11) begin miscompares++; $display("FAIL full_head: got %h want 11", bus.mem_rsp_data_o); end
    pop();
    vectors++; if (bus.mem_req_rdy_o !== 1'b1) begin miscompares++; $display("FAIL full_rdy_after_pop: got %b want 1", bus.mem_req_rdy_o); end
    @(negedge clk);
    bus.mem_req_val_i = 1'b0;
    vectors++; if (bus.mem_rsp_data_o !== 64'h22) begin miscompares++; $display("FAIL full_second: got %h want 22", bus.mem_rsp_data_o); end
    pop();
    wait_rsp();
    vectors++; if (bus.mem_rsp_data_o !== 64'h33) begin miscompares++; $display("FAIL full_third: got %h want 33", bus.mem_rsp_data_o); end
    pop();
    vectors++; if (bus.mem_rsp_val_o !== 1'b0) begin miscompares++; $display("FAIL full_drained: val=%b want 0", bus.mem_rsp_val_o); end
  endtask

  task automatic test_bad();
    logic [DW-1:0] addrs [2];
    addrs[0] = 64'h3;
    addrs[1] = 64'(MD * 8);
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b0, addrs[i], 64'h0);
      vectors++; if (sram_en !== 1'b0) begin miscompares++; $display("FAIL bad%0d_no_en: en=%b want 0", i, sram_en); end
      @(negedge clk);
      vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'hFFFF_FFFF_FFFF_FFFF || err !== 1'b1) begin
        miscompares++; $display("FAIL bad%0d_rsp: val=%b data=%h err=%b want 1 ffffffffffffffff 1", i, bus.mem_rsp_val_o, bus.mem_rsp_data_o, err); end
      pop();
    end
    repeat (3) @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_swap();
    send(1'b1, 1'b0, 64'hC0, 64'h7);
    wait_rsp(); pop();
    send(1'b1, 1'b1, 64'hC0, 64'h9);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin miscompares++; $display("FAIL rst_swap_sram: en=%b we=%b want 0 0", sram_en, sram_we); end
    @(negedge clk);
    vectors++; if (bus.mem_rsp_val_o !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_swap_state: val=%b err=%b want 0 0", bus.mem_rsp_val_o, err); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.mem_req_rdy_o !== 1'b1 || bus.mem_rsp_val_o !== 1'b0) begin
      miscompares++; $display("FAIL rst_swap_release: rdy=%b val=%b want 1 0", bus.mem_req_rdy_o, bus.mem_rsp_val_o); end
    send(1'b0, 1'b0, 64'hC0, 64'h0);
    wait_rsp();
    vectors++; if (bus.mem_rsp_data_o !== 64'h7) begin miscompares++; $display("FAIL rst_swap_nowrite: got %h want 7", bus.mem_rsp_data_o); end
    pop();
  endtask

  task automatic test_back_to_back();
    send(1'b1, 1'b0, 64'h300, 64'hB0);
    wait_rsp();
    for (int i = 1; i < 4; i++) begin
      send(1'b1, 1'b0, 64'h300 + 64'(8 * i), 64'hB0 + 64'(i));
      // Pop the previous response in the same cycle the new one is pushed
      pop();
      vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'hB0 + 64'(i) || bus.mem_req_rdy_o !== 1'b1) begin
        miscompares++; $display("FAIL b2b_pushpop%0d: val=%b data=%h rdy=%b want 1 %h 1", i, bus.mem_rsp_val_o, bus.mem_rsp_data_o, bus.mem_req_rdy_o, 64'hB0 + 64'(i)); end
    end
    pop();
    bus.mem_rsp_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, 64'h400 + 64'(8 * i), 64'hC0 + 64'(i));
      @(negedge clk);
      vectors++; if (bus.mem_rsp_val_o !== 1'b1 || bus.mem_rsp_data_o !== 64'hC0 + 64'(i)) begin
        miscompares++; $display("FAIL b2b_stream%0d: val=%b data=%h want 1 %h", i, bus.mem_rsp_val_o, bus.mem_rsp_data_o, 64'hC0 + 64'(i)); end
    end
    @(negedge clk);
    bus.mem_rsp_rdy_i = 1'b0;
    vectors++; if (bus.mem_rsp_val_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: val=%b want 0", bus.mem_rsp_val_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_req_val_i = 1'b0; bus.mem_req_is_write_i = 1'b0; bus.mem_req_is_cas_i = 1'b0;
    bus.mem_req_addr_i = '0; bus.mem_req_data_i = '0; bus.mem_rsp_rdy_i = 1'b0;
    test_reset();
    test_wr_rd();
    test_swap();
    test_full();
    test_bad();
    test_reset_swap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
